// File: rtl/sram_port_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter_pkg
//  Description : Shared types for the SRAM port arbiter: FSM state encoding,
//                port-owner encoding and default bus widths.
//  Revision    : 1.0 - initial release
// ============================================================================
package sram_port_arbiter_pkg;

    // Arbiter sequencing states; encodings are fixed so traces stay readable
    typedef enum logic [1:0] {
        S_IDLE   = 2'b00,
        S_SETUP  = 2'b01,
        S_ACCESS = 2'b11,
        S_DONE   = 2'b10
    } state_t;

    // Which requester currently owns the SRAM
    typedef enum logic {
        OWN_WR = 1'b0,
        OWN_RD = 1'b1
    } owner_t;

    localparam int C_ADDR_W_DEF = 19;
    localparam int C_DATA_W_DEF = 16;

endpackage : sram_port_arbiter_pkg
`default_nettype wire

// File: rtl/sram_arb_pick.sv
`default_nettype none
// ============================================================================
//  Module      : sram_arb_pick
//  Description : Combinational winner selection between the camera-write and
//                image-out read requesters. Macro SRAM_ARB_RR_EN selects
//                round-robin on conflict; otherwise the write side always wins.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_arb_pick
    import sram_port_arbiter_pkg::*;
(
    input  logic   i_wr_req,
    input  logic   i_rd_req,
    input  owner_t i_rr_ptr,
    output logic   o_valid,
    output owner_t o_owner
);

`ifdef SRAM_ARB_RR_EN
    // On conflict the pointer names the preferred side; a lone request wins
    always_comb begin
        o_valid = i_wr_req | i_rd_req;
        o_owner = OWN_WR;
        if (i_wr_req && i_rd_req) begin
            o_owner = i_rr_ptr;
        end else if (i_rd_req) begin
            o_owner = OWN_RD;
        end
    end
`else
    // Pointer is irrelevant under fixed priority
    logic w_unused_ptr;
    assign w_unused_ptr = i_rr_ptr;

    // Fixed priority: the camera must never stall, so write always wins
    always_comb begin
        o_valid = i_wr_req | i_rd_req;
        o_owner = i_wr_req ? OWN_WR : (i_rd_req ? OWN_RD : OWN_WR);
    end
`endif

endmodule : sram_arb_pick
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : sram_port_arbiter
//  Description : Two-port arbiter sharing one asynchronous SRAM between a
//                camera write stream and an image-out read stream. Each
//                access is SETUP (1) + ACCESS (ACCESS_CYC) + DONE (1) cycles.
//                Macro SRAM_ARB_RR_EN enables round-robin on conflict.
//  Revision    : 1.0 - initial release
// ============================================================================
module sram_port_arbiter
    import sram_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = C_ADDR_W_DEF,
    parameter int DATA_W     = C_DATA_W_DEF,
    parameter int ACCESS_CYC = 2
)(
    input  logic              wclk,
    input  logic              rst,
    input  logic              enable,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              selec_sram,
    output logic              write_sram,
    output logic              read_sram,
    output logic [ADDR_W-1:0] addr_sram,
    output logic [DATA_W-1:0] dout_sram,
    input  logic [DATA_W-1:0] din_sram,
    output logic              busy
);

    // Last value of the strobe counter inside S_ACCESS
    localparam logic [3:0] c_last_cnt = 4'(ACCESS_CYC - 1);

    state_t              r_state;
    state_t              w_state_nxt;
    owner_t              r_owner;
    owner_t              r_rr_ptr;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W-1:0]   r_rd_data;
    logic [3:0]          r_cnt;
    logic                w_grant;
    logic                w_last;
    logic                w_pick_valid;
    owner_t              w_pick_owner;

    sram_arb_pick u_pick (
        .i_wr_req (wr_req),
        .i_rd_req (rd_req),
        .i_rr_ptr (r_rr_ptr),
        .o_valid  (w_pick_valid),
        .o_owner  (w_pick_owner)
    );

    assign w_last    = (r_cnt == c_last_cnt);
    assign busy      = (r_state != S_IDLE);
    assign addr_sram = r_addr;
    assign dout_sram = r_data;
    assign rd_data   = r_rd_data;

    // State register; reset aborts any access in flight without an ack
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and Moore-style SRAM control / ack decode
    always_comb begin
        w_state_nxt = r_state;
        w_grant     = 1'b0;
        selec_sram  = 1'b0;
        write_sram  = 1'b0;
        read_sram   = 1'b0;
        wr_ack      = 1'b0;
        rd_ack      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (enable && w_pick_valid) begin
                    w_grant     = 1'b1;
                    w_state_nxt = S_SETUP;
                end
            end
            S_SETUP: begin
                selec_sram  = 1'b1;
                w_state_nxt = S_ACCESS;
            end
            S_ACCESS: begin
                selec_sram = 1'b1;
                write_sram = (r_owner == OWN_WR);
                read_sram  = (r_owner == OWN_RD);
                if (w_last) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                wr_ack      = (r_owner == OWN_WR);
                rd_ack      = (r_owner == OWN_RD);
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant latch, strobe counter, read capture and round-robin pointer
    always_ff @(posedge wclk or posedge rst) begin
        if (rst) begin
            r_owner   <= OWN_WR;
            r_rr_ptr  <= OWN_WR;
            r_addr    <= '0;
            r_data    <= '0;
            r_rd_data <= '0;
            r_cnt     <= '0;
        end else begin
            if (w_grant) begin
                // Requester inputs are snapshotted here and ignored afterwards
                r_owner  <= w_pick_owner;
                r_addr   <= (w_pick_owner == OWN_WR) ? wr_addr : rd_addr;
                r_data   <= wr_data;
                r_rr_ptr <= (w_pick_owner == OWN_WR) ? OWN_RD : OWN_WR;
            end
            if (r_state == S_SETUP) begin
                r_cnt <= '0;
            end else if (r_state == S_ACCESS) begin
                r_cnt <= r_cnt + 4'd1;
                if (w_last && (r_owner == OWN_RD)) begin
                    r_rd_data <= din_sram;
                end
            end
        end
    end

endmodule : sram_port_arbiter
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sram_port_arbiter
//  Description : Directed self-checking bench for sram_port_arbiter
//                (ACCESS_CYC = 2). Expectations for conflict ordering follow
//                the SRAM_ARB_RR_EN macro when the bench is built with it.
//  Revision    : 1.0 - initial release
// ============================================================================
`define CHK(tag, obs, exp) \
    begin \
        checks++; \
        assert ((obs) === (exp)) else begin \
            errors++; \
            $error("FAIL %s: observed %0h expected %0h", tag, (obs), (exp)); \
        end \
    end

module tb_sram_port_arbiter;

    localparam int AW = 19;
    localparam int DW = 16;
    localparam int AC = 2;

    logic          wclk = 1'b0;
    logic          rst;
    logic          enable;
    logic          wr_req;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_ack;
    logic          rd_req;
    logic [AW-1:0] rd_addr;
    logic          rd_ack;
    logic [DW-1:0] rd_data;
    logic          selec_sram;
    logic          write_sram;
    logic          read_sram;
    logic [AW-1:0] addr_sram;
    logic [DW-1:0] dout_sram;
    logic [DW-1:0] din_sram;
    logic          busy;

    int checks = 0;
    int errors = 0;

    sram_port_arbiter #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .ACCESS_CYC (AC)
    ) dut (
        .wclk       (wclk),
        .rst        (rst),
        .enable     (enable),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rd_req     (rd_req),
        .rd_addr    (rd_addr),
        .rd_ack     (rd_ack),
        .rd_data    (rd_data),
        .selec_sram (selec_sram),
        .write_sram (write_sram),
        .read_sram  (read_sram),
        .addr_sram  (addr_sram),
        .dout_sram  (dout_sram),
        .din_sram   (din_sram),
        .busy       (busy)
    );

    always #5 wclk = ~wclk;

    // Per-cycle protocol invariants on the SRAM side and the ack pair
    always @(negedge wclk) begin
        checks++;
        assert (!(write_sram && read_sram) &&
                !((write_sram || read_sram) && !selec_sram) &&
                !(wr_ack && rd_ack))
        else begin
            errors++;
            $error("FAIL invariant: observed w=%0b r=%0b sel=%0b wack=%0b rack=%0b expected no overlap",
                   write_sram, read_sram, selec_sram, wr_ack, rd_ack);
        end
    end

    task automatic step();
        @(posedge wclk);
        #1;
    endtask

    initial begin : stim
        int   waited;
        logic got;
        logic exp_rd;

        rst      = 1'b1;
        enable   = 1'b0;
        wr_req   = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        rd_req   = 1'b0;
        rd_addr  = '0;
        din_sram = '0;
        #2;
        // Reset state
        `CHK("rst_busy",  busy,       1'b0)
        `CHK("rst_selec", selec_sram, 1'b0)
        `CHK("rst_wack",  wr_ack,     1'b0)
        `CHK("rst_rack",  rd_ack,     1'b0)
        `CHK("rst_addr",  addr_sram,  19'h0)
        `CHK("rst_dout",  dout_sram,  16'h0)
        `CHK("rst_rdata", rd_data,    16'h0)
        step();
        step();
        rst = 1'b0;
        step();

        // ---- Write alone ----
        enable  = 1'b1;
        wr_req  = 1'b1;
        wr_addr = 19'h00010;
        wr_data = 16'hA5A5;
        step();                                    // grant edge -> SETUP
        `CHK("wr_setup_sel",   selec_sram, 1'b1)
        `CHK("wr_setup_wstb",  write_sram, 1'b0)
        `CHK("wr_setup_addr",  addr_sram,  19'h00010)
        `CHK("wr_setup_busy",  busy,       1'b1)
        step();
        `CHK("wr_acc1_wstb",   write_sram, 1'b1)
        `CHK("wr_acc1_dout",   dout_sram,  16'hA5A5)
        `CHK("wr_acc1_ack",    wr_ack,     1'b0)
        step();
        `CHK("wr_acc2_wstb",   write_sram, 1'b1)
        `CHK("wr_acc2_ack",    wr_ack,     1'b0)
        step();                                    // 4 edges after sample
        `CHK("wr_done_ack",    wr_ack,     1'b1)
        `CHK("wr_done_wstb",   write_sram, 1'b0)
        `CHK("wr_done_sel",    selec_sram, 1'b0)
        wr_req = 1'b0;
        step();
        `CHK("wr_idle_ack",    wr_ack,     1'b0)
        `CHK("wr_idle_busy",   busy,       1'b0)

        // ---- Read alone, inputs changed/dropped after grant ----
        rd_req   = 1'b1;
        rd_addr  = 19'h7FFFF;
        din_sram = 16'h1234;
        step();                                    // SETUP
        rd_addr = 19'h00000;
        rd_req  = 1'b0;
        `CHK("rd_setup_addr",  addr_sram,  19'h7FFFF)
        step();
        `CHK("rd_acc1_rstb",   read_sram,  1'b1)
        `CHK("rd_acc1_addr",   addr_sram,  19'h7FFFF)
        step();
        `CHK("rd_acc2_rstb",   read_sram,  1'b1)
        step();
        `CHK("rd_done_ack",    rd_ack,     1'b1)
        `CHK("rd_done_wack",   wr_ack,     1'b0)
        `CHK("rd_done_data",   rd_data,    16'h1234)
        din_sram = 16'hBEEF;
        step();
        `CHK("rd_hold_data",   rd_data,    16'h1234)
        `CHK("rd_idle_busy",   busy,       1'b0)

        // ---- Conflict: both held for four accesses ----
        rst = 1'b1;
        #1;
        rst = 1'b0;
        wr_addr = 19'h00001;
        rd_addr = 19'h00002;
        wr_req  = 1'b1;
        rd_req  = 1'b1;
        for (int k = 0; k < 4; k++) begin
            waited = 0;
            got    = 1'b0;
            while (!got && waited < 12) begin
                step();
                waited++;
                if (wr_ack || rd_ack) got = 1'b1;
            end
`ifdef SRAM_ARB_RR_EN
            exp_rd = (k % 2) == 1;
`else
            exp_rd = 1'b0;
`endif
            `CHK("cf_ack_seen", got,       1'b1)
            `CHK("cf_latency",  waited,    ((k == 0) ? 4 : 5))
            `CHK("cf_wr_ack",   wr_ack,    ~exp_rd)
            `CHK("cf_rd_ack",   rd_ack,    exp_rd)
            `CHK("cf_addr",     addr_sram, (exp_rd ? 19'h00002 : 19'h00001))
        end
        wr_req = 1'b0;
        rd_req = 1'b0;
        step();
        `CHK("cf_idle_busy", busy, 1'b0)

        // ---- Reset during S_ACCESS ----
        wr_req  = 1'b1;
        wr_addr = 19'h00055;
        step();                                    // SETUP
        wr_req = 1'b0;
        step();                                    // ACCESS
        `CHK("ra_pre_wstb", write_sram, 1'b1)
        rst = 1'b1;
        #1;
        `CHK("ra_sel",   selec_sram, 1'b0)
        `CHK("ra_wstb",  write_sram, 1'b0)
        `CHK("ra_rstb",  read_sram,  1'b0)
        `CHK("ra_addr",  addr_sram,  19'h0)
        `CHK("ra_busy",  busy,       1'b0)
        step();
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            `CHK("ra_no_ack",  wr_ack, 1'b0)
            `CHK("ra_idle",    busy,   1'b0)
        end

        // ---- enable gating ----
        enable = 1'b0;
        wr_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            `CHK("en_off_busy", busy,       1'b0)
            `CHK("en_off_sel",  selec_sram, 1'b0)
        end
        enable = 1'b1;
        step();
        `CHK("en_on_busy", busy, 1'b1)
        enable = 1'b0;                             // falls mid-transaction
        step();
        step();
        step();
        `CHK("en_fall_ack", wr_ack, 1'b1)
        step();
        `CHK("en_fall_nogrant", busy, 1'b0)
        step();
        `CHK("en_fall_idle", busy, 1'b0)
        wr_req = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Safety net in case stimulus ever stalls
    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule : tb_sram_port_arbiter
`default_nettype wire
